// File: rtl/spi_frame_pkg.sv
// Shared constants and frame-parser state encoding for the SPI slave frame receiver.
// Frame layout: AA 55 <type> followed by a type-specific payload.
package spi_frame_pkg;

   localparam logic [7:0] SYNC0  = 8'hAA;
   localparam logic [7:0] SYNC1  = 8'h55;
   localparam logic [7:0] T_LEN  = 8'hA4;
   localparam logic [7:0] T_ADDR = 8'hA5;
   localparam logic [7:0] T_DATA = 8'hA6;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_PRE1   = 4'd1,
      ST_TYPE   = 4'd2,
      ST_LEN_H  = 4'd3,
      ST_LEN_L  = 4'd4,
      ST_ADDR_H = 4'd5,
      ST_ADDR_L = 4'd6,
      ST_DATA_H = 4'd7,
      ST_DATA_L = 4'd8
   } frame_state_e;

endpackage

// File: rtl/spi_slave_byte_rx.sv
// SPI mode-3 byte receiver: synchronisers, SCK edge detect, MSB-first shift register, byte_vld pulse.
// Optional MISO echo of the previous complete byte under SPI_RX_MISO_ECHO_EN.
module spi_slave_byte_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       spi_cs_n_i,
   input  logic       spi_sck_i,
   input  logic       spi_mosi_i,
   output logic       spi_miso_o,
   output logic       byte_vld_o,
   output logic [7:0] byte_dat_o,
   output logic       cs_rise_o,
   output logic       partial_o
);

   logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
   logic                   cs_s, sck_s, mosi_s;
   logic                   cs_prev_q, sck_prev_q;
   logic                   sck_rise;
   logic [7:0]             shift_q, shift_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   byte_vld_q, byte_vld_d;
   logic [7:0]             byte_q, byte_d;

   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sck_s     = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise  = sck_s & ~sck_prev_q;
   assign cs_rise_o = cs_s & ~cs_prev_q;
   assign partial_o = (bit_cnt_q != 3'd0);

   always_comb begin
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      byte_vld_d = 1'b0;
      byte_d     = byte_q;
      if (cs_s) begin
         bit_cnt_d = 3'd0;
      end else if (sck_rise) begin
         shift_d = {shift_q[6:0], mosi_s};
         if (bit_cnt_q == 3'd7) begin
            bit_cnt_d  = 3'd0;
            byte_vld_d = 1'b1;
            byte_d     = {shift_q[6:0], mosi_s};
         end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cs_sync_q   <= '1;
         sck_sync_q  <= '1;
         mosi_sync_q <= '0;
         cs_prev_q   <= 1'b1;
         sck_prev_q  <= 1'b1;
         shift_q     <= 8'd0;
         bit_cnt_q   <= 3'd0;
         byte_vld_q  <= 1'b0;
         byte_q      <= 8'd0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
         cs_prev_q   <= cs_s;
         sck_prev_q  <= sck_s;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_vld_q  <= byte_vld_d;
         byte_q      <= byte_d;
      end
   end

   assign byte_vld_o = byte_vld_q;
   assign byte_dat_o = byte_q;

`ifdef SPI_RX_MISO_ECHO_EN
   logic       sck_fall;
   logic [7:0] tx_q, tx_d;

   assign sck_fall = ~sck_s & sck_prev_q;

   // The first falling edge of a byte presents the MSB, so it must not shift.
   always_comb begin
      tx_d = tx_q;
      if (byte_vld_d) begin
         tx_d = byte_d;
      end else if (sck_fall && !cs_s && (bit_cnt_q != 3'd0)) begin
         tx_d = {tx_q[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         tx_q <= 8'd0;
      end else begin
         tx_q <= tx_d;
      end
   end

   assign spi_miso_o = cs_s ? 1'b0 : tx_q[7];
`else
   assign spi_miso_o = 1'b0;
`endif

endmodule

// File: rtl/spi_slave_frame_rx.sv
// SPI mode-3 slave frame parser: decodes AA 55 <A4|A5|A6> frames into length, base address and write strobes.
// Optional MISO echo of the last received byte is enabled by defining SPI_RX_MISO_ECHO_EN.
module spi_slave_frame_rx
   import spi_frame_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_cs_n,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [15:0]       data_len,
   output logic              len_valid,
   output logic              addr_valid,
   output logic              frame_err
);

   logic       byte_vld;
   logic [7:0] rx_byte;
   logic       cs_rise;
   logic       partial;

   spi_slave_byte_rx #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_byte_rx (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .spi_cs_n_i (spi_cs_n),
      .spi_sck_i  (spi_sck),
      .spi_mosi_i (spi_mosi),
      .spi_miso_o (spi_miso),
      .byte_vld_o (byte_vld),
      .byte_dat_o (rx_byte),
      .cs_rise_o  (cs_rise),
      .partial_o  (partial)
   );

   frame_state_e      state_q, state_d;
   logic [7:0]        len_hi_q, len_hi_d;
   logic [7:0]        addr_hi_q, addr_hi_d;
   logic [7:0]        data_hi_q, data_hi_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [15:0]       word_cnt_q, word_cnt_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [15:0]       data_len_q, data_len_d;
   logic              len_valid_q, len_valid_d;
   logic              addr_valid_q, addr_valid_d;
   logic              frame_err_q, frame_err_d;

   always_comb begin
      state_d      = state_q;
      len_hi_d     = len_hi_q;
      addr_hi_d    = addr_hi_q;
      data_hi_d    = data_hi_q;
      base_d       = base_q;
      ptr_d        = ptr_q;
      word_cnt_d   = word_cnt_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      data_len_d   = data_len_q;
      len_valid_d  = len_valid_q;
      addr_valid_d = addr_valid_q;
      frame_err_d  = 1'b0;

      // A chip-select release aborts any frame and drops a byte arriving in the same cycle.
      if (cs_rise) begin
         state_d     = ST_IDLE;
         frame_err_d = (state_q != ST_IDLE) || partial;
      end else if (byte_vld) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == SYNC0) state_d = ST_PRE1;
            end
            ST_PRE1: begin
               if (rx_byte == SYNC1) begin
                  state_d = ST_TYPE;
               end else begin
                  state_d     = ST_IDLE;
                  frame_err_d = 1'b1;
               end
            end
            ST_TYPE: begin
               if (rx_byte == T_LEN) begin
                  state_d = ST_LEN_H;
               end else if (rx_byte == T_ADDR) begin
                  state_d = ST_ADDR_H;
               end else if (rx_byte == T_DATA && len_valid_q && addr_valid_q &&
                            data_len_q != 16'd0) begin
                  state_d    = ST_DATA_H;
                  ptr_d      = base_q;
                  word_cnt_d = 16'd0;
               end else begin
                  state_d     = ST_IDLE;
                  frame_err_d = 1'b1;
               end
            end
            ST_LEN_H: begin
               len_hi_d = rx_byte;
               state_d  = ST_LEN_L;
            end
            ST_LEN_L: begin
               data_len_d  = {len_hi_q, rx_byte};
               len_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end
            ST_ADDR_H: begin
               addr_hi_d = rx_byte;
               state_d   = ST_ADDR_L;
            end
            ST_ADDR_L: begin
               base_d       = ADDR_W'({addr_hi_q, rx_byte});
               ptr_d        = ADDR_W'({addr_hi_q, rx_byte});
               word_cnt_d   = 16'd0;
               addr_valid_d = 1'b1;
               state_d      = ST_IDLE;
            end
            ST_DATA_H: begin
               data_hi_d = rx_byte;
               state_d   = ST_DATA_L;
            end
            ST_DATA_L: begin
               wr_en_d    = 1'b1;
               wr_addr_d  = ptr_q;
               wr_data_d  = DATA_W'({data_hi_q, rx_byte});
               ptr_d      = ptr_q + ADDR_W'(1);
               word_cnt_d = word_cnt_q + 16'd1;
               state_d    = ((word_cnt_q + 16'd1) == data_len_q) ? ST_IDLE : ST_DATA_H;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         len_hi_q     <= 8'd0;
         addr_hi_q    <= 8'd0;
         data_hi_q    <= 8'd0;
         base_q       <= '0;
         ptr_q        <= '0;
         word_cnt_q   <= 16'd0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         data_len_q   <= 16'd0;
         len_valid_q  <= 1'b0;
         addr_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_hi_q     <= len_hi_d;
         addr_hi_q    <= addr_hi_d;
         data_hi_q    <= data_hi_d;
         base_q       <= base_d;
         ptr_q        <= ptr_d;
         word_cnt_q   <= word_cnt_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         data_len_q   <= data_len_d;
         len_valid_q  <= len_valid_d;
         addr_valid_q <= addr_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign data_len   = data_len_q;
   assign len_valid  = len_valid_q;
   assign addr_valid = addr_valid_q;
   assign frame_err  = frame_err_q;

endmodule
